// File: rtl/lix_shr_sink.sv
// Credit-based receive end for a fixed-latency, stall-free pipeline.
// Launch credits mirror FIFO slots, so every item in flight has a slot reserved for it.
module lix_shr_sink #(
  parameter int W     = 32,
  parameter int N     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic         o_crdy,
  input  logic         i_launch,
  input  logic         i_vld,
  input  logic [W-1:0] i_x,
  output logic         o_vld,
  output logic [W-1:0] o_z,
  input  logic         i_rdy,
  output logic         o_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] crd;
  logic          err;
  logic          take;
  logic          give;
  logic          ret;
  logic          wr;

  // N only documents the full-throughput sizing rule DEPTH >= N+1.
  logic [31:0] lat_unused;
  assign lat_unused = 32'(N);

  assign o_crdy = (crd != '0);
  assign o_vld  = (cnt != '0);
  assign o_z    = mem[rd_ptr];
  assign o_err  = err;

  assign take = i_launch & o_crdy;
  assign give = o_vld & i_rdy;
  assign ret  = give & (crd != FULL);
  assign wr   = i_vld & ((cnt != FULL) | give);

  // A read with no credit outstanding returns nothing, so crd saturates at DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crd <= FULL;
    end else begin
      case ({take, ret})
        2'b10:   crd <= crd - ONE;
        2'b01:   crd <= crd + ONE;
        default: crd <= crd;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      case ({wr, give})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
      if (wr) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PONE;
      end
      if (give) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else begin
      err <= err | (i_launch & ~o_crdy) | (i_vld & (cnt == FULL) & ~give) | (give & (crd == FULL));
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem[wr_ptr] <= i_x;
    end
  end

endmodule

// File: tb/tb_lix_shr_sink.sv
// Bench for lix_shr_sink: DEPTH=4 and DEPTH=3 instances, each fed by a 2-stage upstream pipeline.
// The reference model keeps a credit count and a queue of items.
module tb_lix_shr_sink;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_launch, a_vld, a_rdy, a_crdy, a_ovld, a_err;
  logic [W-1:0] a_x, a_z;
  logic         b_launch, b_vld, b_rdy, b_crdy, b_ovld, b_err;
  logic [W-1:0] b_x, b_z;

  lix_shr_sink #(.W(W), .N(2), .DEPTH(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .o_crdy(a_crdy), .i_launch(a_launch), .i_vld(a_vld),
    .i_x(a_x), .o_vld(a_ovld), .o_z(a_z), .i_rdy(a_rdy), .o_err(a_err)
  );

  lix_shr_sink #(.W(W), .N(2), .DEPTH(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .o_crdy(b_crdy), .i_launch(b_launch), .i_vld(b_vld),
    .i_x(b_x), .o_vld(b_ovld), .o_z(b_z), .i_rdy(b_rdy), .o_err(b_err)
  );

  int total = 0;
  int bad   = 0;

  int           m_crd;
  bit           m_err;
  logic [W-1:0] m_q[$];

  logic         pa_v [2];
  logic [W-1:0] pa_d [2];
  logic         pb_v [2];
  logic [W-1:0] pb_d [2];

  function automatic logic [2:0] exp_a();
    return {m_crd != 0, m_q.size() != 0, m_err};
  endfunction

  task automatic clear_all();
    a_launch = 0; a_vld = 0; a_rdy = 0; a_x = '0;
    b_launch = 0; b_vld = 0; b_rdy = 0; b_x = '0;
    for (int i = 0; i < 2; i++) begin
      pa_v[i] = 0; pa_d[i] = '0; pb_v[i] = 0; pb_d[i] = '0;
    end
    m_crd = 4; m_err = 0; m_q.delete();
  endtask

  task automatic do_reset();
    rst = 1;
    clear_all();
    #2 rst = 0;
    @(posedge clk); #1;
  endtask

  // One cycle on instance A: pipeline tail (or an injected item) drives i_vld/i_x.
  task automatic cycle_a(input logic launch, input logic [W-1:0] x, input logic rdy,
                         input logic inj, input logic [W-1:0] inj_x);
    logic tv;
    logic [W-1:0] td;
    bit take, give, full;
    tv = pa_v[1] | inj;
    td = inj ? inj_x : pa_d[1];
    a_launch = launch; a_x = td; a_vld = tv; a_rdy = rdy;
    take = launch && (m_crd > 0);
    give = (m_q.size() > 0) && rdy;
    full = (m_q.size() == 4);
    if (launch && m_crd == 0) m_err = 1;
    if (give && m_crd == 4) m_err = 1;
    if (tv && full && !give) m_err = 1;
    m_crd = m_crd - int'(take) + int'(give && m_crd != 4);
    if (give) void'(m_q.pop_front());
    if (tv && (!full || give)) m_q.push_back(td);
    @(posedge clk);
    pa_v[1] = pa_v[0]; pa_d[1] = pa_d[0];
    pa_v[0] = launch;  pa_d[0] = x;
    #1;
  endtask

  task automatic cycle_b(input logic launch, input logic [W-1:0] x, input logic rdy);
    b_launch = launch; b_vld = pb_v[1]; b_x = pb_d[1]; b_rdy = rdy;
    @(posedge clk);
    pb_v[1] = pb_v[0]; pb_d[1] = pb_d[0];
    pb_v[0] = launch;  pb_d[0] = x;
    #1;
  endtask

  task automatic fill_a(output logic [W-1:0] sent[$]);
    logic [W-1:0] x;
    sent.delete();
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      if (i < 4) sent.push_back(x);
      cycle_a(i < 4, x, 0, 0, '0);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] sent[$];
    #3;
    total++;
    if ({a_crdy, a_ovld, a_err} !== 3'b100) begin
      bad++; $display("FAIL reset_a: got %b want 100", {a_crdy, a_ovld, a_err});
    end
    total++;
    if ({b_crdy, b_ovld, b_err} !== 3'b100) begin
      bad++; $display("FAIL reset_b: got %b want 100", {b_crdy, b_ovld, b_err});
    end
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) cycle_a(i < 4, $urandom, 0, 0, '0);
    total++;
    if ({a_crdy, a_ovld, a_err} !== 3'b010) begin
      bad++; $display("FAIL pre_reset_state: got %b want 010", {a_crdy, a_ovld, a_err});
    end
    #3 rst = 1;
    #1;
    total++;
    if ({a_crdy, a_ovld, a_err} !== 3'b100) begin
      bad++; $display("FAIL async_reset: got %b want 100", {a_crdy, a_ovld, a_err});
    end
    #1 rst = 0;
    clear_all();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      cycle_a(1, $urandom, 0, 0, '0);
      total++;
      if (a_crdy !== (i < 3)) begin
        bad++; $display("FAIL reset_credits[%0d]: got %b want %b", i, a_crdy, i < 3);
      end
    end
  endtask

  task automatic test_streaming();
    bit crdy_low = 0;
    do_reset();
    for (int j = 1; j <= 13; j++) begin
      cycle_a(j <= 10, 32'(j - 1), 1, 0, '0);
      if (a_crdy !== 1'b1) crdy_low = 1;
      total++;
      if ({a_crdy, a_ovld, a_err} !== exp_a()) begin
        bad++; $display("FAIL stream_flags[%0d]: got %b want %b", j, {a_crdy, a_ovld, a_err}, exp_a());
      end
      if (j >= 3 && j <= 12) begin
        total++;
        if (a_ovld !== 1'b1 || a_z !== 32'(j - 3)) begin
          bad++; $display("FAIL stream_data[%0d]: got vld=%b z=%h want vld=1 z=%h", j, a_ovld, a_z, 32'(j - 3));
        end
      end
    end
    total++;
    if (crdy_low !== 1'b0 || a_err !== 1'b0) begin
      bad++; $display("FAIL stream_crdy_err: got low=%b err=%b want 0 0", crdy_low, a_err);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] sent[$];
    logic [W-1:0] x, e;
    logic l;
    int acc = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      l = a_crdy;
      x = $urandom;
      if (l) begin acc++; sent.push_back(x); end
      cycle_a(l, x, 0, 0, '0);
      if (i == 3) begin
        total++;
        if (a_crdy !== 1'b0) begin
          bad++; $display("FAIL bp_crdy_low: got %b want 0", a_crdy);
        end
      end
    end
    total++;
    if (acc != 4 || {a_crdy, a_ovld, a_err} !== exp_a()) begin
      bad++; $display("FAIL bp_accepted: got %0d flags %b want 4 flags %b", acc, {a_crdy, a_ovld, a_err}, exp_a());
    end
    for (int i = 0; i < 6; i++) begin
      if (a_ovld === 1'b1) begin
        total++;
        e = (sent.size() > 0) ? sent.pop_front() : 'x;
        if (a_z !== e) begin
          bad++; $display("FAIL bp_drain[%0d]: got %h want %h", i, a_z, e);
        end
      end
      cycle_a(0, '0, 1, 0, '0);
      if (i == 0) begin
        total++;
        if (a_crdy !== 1'b1) begin
          bad++; $display("FAIL bp_crdy_return: got %b want 1", a_crdy);
        end
      end
    end
    total++;
    if (sent.size() != 0 || a_err !== 1'b0) begin
      bad++; $display("FAIL bp_leftover: got %0d left err=%b want 0 left err=0", sent.size(), a_err);
    end
  endtask

  task automatic test_full_rw();
    logic [W-1:0] sent[$];
    logic [W-1:0] nx, e;
    do_reset();
    fill_a(sent);
    total++;
    if ({a_crdy, a_ovld, a_err} !== 3'b010) begin
      bad++; $display("FAIL full_state: got %b want 010", {a_crdy, a_ovld, a_err});
    end
    nx = $urandom;
    cycle_a(0, '0, 1, 1, nx);
    void'(sent.pop_front());
    sent.push_back(nx);
    total++;
    if ({a_crdy, a_ovld, a_err} !== exp_a() || m_q.size() != 4) begin
      bad++; $display("FAIL full_rw_flags: got %b want %b", {a_crdy, a_ovld, a_err}, exp_a());
    end
    for (int i = 0; i < 3; i++) begin
      e = sent.pop_front();
      total++;
      if (a_z !== e) begin
        bad++; $display("FAIL full_rw_order[%0d]: got %h want %h", i, a_z, e);
      end
      cycle_a(0, '0, 1, 0, '0);
    end
    total++;
    if (a_ovld !== 1'b1 || a_z !== nx || a_err !== 1'b0) begin
      bad++; $display("FAIL full_rw_last: got vld=%b z=%h err=%b want 1 %h 0", a_ovld, a_z, a_err, nx);
    end
  endtask

  task automatic test_errors();
    logic [W-1:0] sent[$];
    logic [W-1:0] e;
    for (int part = 0; part < 2; part++) begin
      do_reset();
      fill_a(sent);
      if (part == 0) cycle_a(1, $urandom, 0, 0, '0);
      else           cycle_a(0, '0, 0, 1, $urandom);
      total++;
      if (a_err !== 1'b1 || a_crdy !== 1'b0) begin
        bad++; $display("FAIL err_set[%0d]: got err=%b crdy=%b want 1 0", part, a_err, a_crdy);
      end
      cycle_a(0, '0, 0, 0, '0);
      cycle_a(0, '0, 0, 0, '0);
      for (int i = 0; i < 4; i++) begin
        e = sent.pop_front();
        total++;
        if (a_ovld !== 1'b1 || a_z !== e) begin
          bad++; $display("FAIL err_contents[%0d.%0d]: got vld=%b z=%h want 1 %h", part, i, a_ovld, a_z, e);
        end
        cycle_a(0, '0, 1, 0, '0);
      end
      total++;
      if (a_ovld !== 1'b0 || a_err !== 1'b1) begin
        bad++; $display("FAIL err_dropped[%0d]: got vld=%b err=%b want 0 1", part, a_ovld, a_err);
      end
    end
    do_reset();
    cycle_a(0, '0, 0, 1, $urandom);
    total++;
    if ({a_crdy, a_ovld, a_err} !== 3'b110) begin
      bad++; $display("FAIL err_inject: got %b want 110", {a_crdy, a_ovld, a_err});
    end
    cycle_a(0, '0, 1, 0, '0);
    total++;
    if ({a_crdy, a_ovld, a_err} !== 3'b101) begin
      bad++; $display("FAIL err_excess_credit: got %b want 101", {a_crdy, a_ovld, a_err});
    end
    for (int i = 0; i < 4; i++) begin
      cycle_a(1, $urandom, 0, 0, '0);
      total++;
      if (a_crdy !== (i < 3)) begin
        bad++; $display("FAIL err_saturate[%0d]: got %b want %b", i, a_crdy, i < 3);
      end
    end
  endtask

  task automatic test_random();
    logic l, r;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      r = 1'($urandom_range(0, 1));
      l = a_crdy & 1'($urandom_range(0, 1));
      cycle_a(l, $urandom, r, 0, '0);
      total++;
      if ({a_crdy, a_ovld, a_err} !== exp_a()) begin
        bad++; $display("FAIL rand_flags[%0d]: got %b want %b", i, {a_crdy, a_ovld, a_err}, exp_a());
      end
      if (m_q.size() > 0) begin
        total++;
        if (a_z !== m_q[0]) begin
          bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, a_z, m_q[0]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] expb[$];
    logic [W-1:0] x, e;
    logic l, r;
    int sentn = 0, got = 0, cyc = 0;
    do_reset();
    while (got < 9 && cyc < 300) begin
      l = (sentn < 9) && b_crdy && ($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      x = $urandom;
      if (l) begin expb.push_back(x); sentn++; end
      if (b_ovld === 1'b1 && r) begin
        e = (expb.size() > 0) ? expb.pop_front() : 'x;
        total++;
        if (b_z !== e) begin
          bad++; $display("FAIL wrap_order[%0d]: got %h want %h", got, b_z, e);
        end
        got++;
      end
      cycle_b(l, x, r);
      cyc++;
    end
    total++;
    if (got != 9 || b_err !== 1'b0) begin
      bad++; $display("FAIL wrap_done: got %0d items err=%b want 9 items err=0", got, b_err);
    end
  endtask

  initial begin
    rst = 1;
    clear_all();
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_rw();
    test_errors();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lix_shr_sink.md
# lix_shr_sink

Credit-based receive end for a fixed-latency stall-free pipeline such as the `lix_shr0` chain. It grants launch credits to the pipeline head and catches items at the pipeline tail in a DEPTH-entry FIFO. It re-times them onto a valid/ready output. Because every launched item holds a reserved FIFO slot, the pipeline never needs to stall even when downstream back-pressures.

## Interface
- `W`, 32, data width
- `N`, 2, pipeline latency in cycles from launch to tail; informational, used only for the full-throughput rule (DEPTH ≥ N+1)
- `DEPTH`, 4, FIFO entries and total credits; any integer ≥ 2, power of two not required
- `clk_i`  in  1  single clock, all state on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `o_crdy`  out  1  credit available; upstream may launch an item into the pipeline head this cycle
- `i_launch`  in  1  upstream launched an item this cycle
- `i_vld`  in  1  valid of the item at the pipeline tail
- `i_x`  in  W  data at the pipeline tail
- `o_vld`  out  1  output item valid
- `o_z`  out  W  output data, the FIFO head
- `i_rdy`  in  1  downstream accepts `o_z` when `o_vld & i_rdy`
- `o_err`  out  1  sticky protocol-error flag

## Operation
**Credit counter `crd`**
- Width is clog2(DEPTH+1); resets to DEPTH.
- `o_crdy = (crd != 0)`, decoded from registers only.
- Taken credit: `take = i_launch & o_crdy`.
- Returned credit: `give = o_vld & i_rdy`.
- Update: `crd <= crd - take + give`. Simultaneous take and give leaves `crd` unchanged.
- Invariant: `crd + occupancy + in-flight = DEPTH`.

**FIFO**
- Storage is DEPTH×W registers with `wr_ptr`, `rd_ptr`, and `cnt` (0..DEPTH). All reset to 0.
- Pointers wrap explicitly from DEPTH-1 to 0.
- Write when `i_vld` and either `cnt < DEPTH` or a read happens in the same cycle.
- Read when `o_vld & i_rdy`.
- Simultaneous read and write: `cnt` unchanged, both pointers advance. This is legal at `cnt == DEPTH`.
- Memory contents are not reset.

**Outputs**
- `o_vld = (cnt != 0)`.
- `o_z = mem[rd_ptr]`. When `cnt == 0`, the value is undefined but stable.

**Errors (`o_err` goes to 1 and stays 1 until reset)**
- `i_launch & !o_crdy`: the launch is ignored and not counted.
- `i_vld` while `cnt == DEPTH` with no read: the item is dropped; `cnt` and `wr_ptr` are unchanged.
- `o_vld & i_rdy` while `crd == DEPTH`: the credit is not returned, and `crd` saturates at DEPTH.

**Reset**
- Asserting `rst_i` at any time clears all state asynchronously, including mid-burst.
- In-flight pipeline items still arriving after reset are written normally. Upstream must reset the pipeline together with this block.

## Timing
Reset values:
- `o_crdy` = 1
- `o_vld` = 0
- `o_err` = 0
- `crd` = DEPTH
- `cnt` = 0

Latencies:
- Tail item with `i_vld` at edge t gives `o_vld` = 1 with that data after edge t. Capture-to-output latency is 1 cycle.
- A launch at cycle t reaches the output no earlier than cycle t+N+1.
- A credit returned at cycle t is visible on `o_crdy` at cycle t+1. A `crd == 0` state recovers in one cycle.

Throughput:
- With DEPTH ≥ N+1 and `i_rdy` held at 1, `o_crdy` stays 1 indefinitely, giving one item per cycle.
- With DEPTH < N+1, `o_crdy` duty falls to DEPTH/(N+1).

Other rules:
- No combinational path from `i_vld`, `i_x`, or `i_launch` to any output.
- `o_crdy` depends combinationally on nothing; it is decoded from registers only.

## Test plan
1. **Reset.** Assert `rst_i` mid-cycle with `cnt=3`, `crd=0` → immediately `o_vld=0`, `o_crdy=1`, `o_err=0`. After release, `crd=4`.
2. **Streaming.** DEPTH=4, N=2, `i_rdy=1`. Launch 10 items and model the pipeline as a 2-cycle delay of `i_launch`/data 0x00..0x09 → `o_z` sequence 0x00..0x09, each 3 cycles after its launch. `o_crdy` never 0, `o_err=0`.
3. **Back-pressure.** `i_rdy=0`, launch every cycle while `o_crdy` → exactly 4 launches accepted, `o_crdy=0` from the 5th cycle, and `cnt` reaches 4. Release `i_rdy` → items drain in order and `o_crdy` returns 1 cycle after the first accept.
4. **Full plus simultaneous read/write.** `cnt=4`, `i_vld=1` and `i_rdy=1` in the same cycle → `cnt` stays 4, the new item is queued behind 3 older ones, no `o_err`.
5. **Errors.** `i_launch=1` with `crd=0` → `o_err=1` next cycle and `crd` stays 0. `i_vld=1` with `cnt=4`, `i_rdy=0` → item dropped and FIFO contents unchanged.
6. **Wrap-around.** DEPTH=3 (not a power of two). Push and pop 9 items with random `i_rdy` → order preserved across three pointer wraps.
